// File: rtl/sensor_pkg.sv
// sensor_pkg: state encoding and default timing constants for the ultrasonic ranger.
package sensor_pkg;

  localparam int unsigned ClkHz             = 50_000_000;
  localparam int unsigned DefTrigCycles     = ClkHz / 100_000;            // 10 us
  localparam int unsigned DefPeriodCycles   = (ClkHz / 1000) * 60;        // 60 ms
  localparam int unsigned DefTimeoutCycles  = (ClkHz / 1000) * 38;        // 38 ms
  localparam int unsigned DefCycPerCm       = (ClkHz / 1_000_000) * 58;   // 58 us per cm
  localparam int unsigned AvgDepth          = 4;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StHoldoff
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/sensor_trigger.sv
// sensor_trigger: ultrasonic ranger initiator - periodic trigger, echo timing, cm conversion.
// Define SENSOR_AVG_EN to output the mean of the last four valid measurements.
module sensor_trigger
  import sensor_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DefTrigCycles,
  parameter int unsigned PERIOD_CYCLES  = DefPeriodCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned CYC_PER_CM     = DefCycPerCm,
  parameter int unsigned DIST_W         = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              timeout,
  output logic              busy
);

  localparam int unsigned PerW = $clog2(PERIOD_CYCLES);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SubW = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;
  localparam logic [DIST_W-1:0] CmMax = '1;

  state_e            state_q;
  logic              trig_q, valid_q, tmo_q;
  logic [DIST_W-1:0] dist_q, cm_q, cm_base, cm_step, dist_new;
  logic [SubW-1:0]   sub_q, sub_base, sub_step;
  logic [PerW-1:0]   per_cnt_q;
  logic [TmoW-1:0]   tmo_cnt_q;
  logic              echo_s, per_wrap, trig_end, tmo_hit, meas_done;

  sync_2ff u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_s)
  );

  assign per_wrap  = per_cnt_q == PerW'(PERIOD_CYCLES - 1);
  assign trig_end  = per_cnt_q == PerW'(TRIG_CYCLES - 1);
  assign tmo_hit   = tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1);
  assign meas_done = (state_q == StMeasure) && !echo_s;

  // The echo-high cycle that moves WAIT_RISE into MEASURE is counted, so the
  // step starts from zero there and from the running counters inside MEASURE.
  always_comb begin
    sub_base = (state_q == StMeasure) ? sub_q : '0;
    cm_base  = (state_q == StMeasure) ? cm_q : '0;
    sub_step = sub_base + 1'b1;
    cm_step  = cm_base;
    if (sub_base == SubW'(CYC_PER_CM - 1)) begin
      sub_step = '0;
      if (cm_base != CmMax) cm_step = cm_base + 1'b1;
    end
  end

`ifdef SENSOR_AVG_EN
  localparam int unsigned FillW = $clog2(AvgDepth) + 1;

  logic [DIST_W-1:0] avg_buf_q [AvgDepth];
  logic [DIST_W+1:0] sum_q, sum_d;
  logic [FillW-1:0]  fill_q;

  // Running sum: drop the oldest entry (zero until the buffer fills), add the newest.
  always_comb begin
    sum_d    = sum_q - {2'b00, avg_buf_q[AvgDepth-1]} + {2'b00, cm_q};
    dist_new = (fill_q >= FillW'(AvgDepth - 1)) ? sum_d[DIST_W+1:2] : cm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AvgDepth; i++) avg_buf_q[i] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (meas_done) begin
      avg_buf_q[0] <= cm_q;
      for (int i = 1; i < AvgDepth; i++) avg_buf_q[i] <= avg_buf_q[i-1];
      sum_q <= sum_d;
      if (fill_q != FillW'(AvgDepth)) fill_q <= fill_q + 1'b1;
    end
  end
`else
  assign dist_new = cm_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
      dist_q    <= '0;
      cm_q      <= '0;
      sub_q     <= '0;
      per_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      if (state_q != StIdle) per_cnt_q <= per_wrap ? '0 : per_cnt_q + 1'b1;
      if (state_q == StWaitRise || state_q == StMeasure) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q   <= StTrig;
            trig_q    <= 1'b1;
            per_cnt_q <= '0;
          end
        end
        StTrig: begin
          if (trig_end) begin
            trig_q    <= 1'b0;
            tmo_cnt_q <= '0;
            state_q   <= StWaitRise;
          end
        end
        StWaitRise: begin
          if (echo_s) begin
            state_q <= StMeasure;
            sub_q   <= sub_step;
            cm_q    <= cm_step;
          end else if (tmo_hit) begin
            tmo_q   <= 1'b1;
            state_q <= StHoldoff;
          end
        end
        StMeasure: begin
          if (!echo_s) begin
            dist_q  <= dist_new;
            valid_q <= 1'b1;
            state_q <= StHoldoff;
          end else if (tmo_hit) begin
            tmo_q   <= 1'b1;
            state_q <= StHoldoff;
          end else begin
            sub_q <= sub_step;
            cm_q  <= cm_step;
          end
        end
        StHoldoff: begin
          if (per_wrap) begin
            if (enable) begin
              state_q <= StTrig;
              trig_q  <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign trig       = trig_q;
  assign distance   = dist_q;
  assign dist_valid = valid_q;
  assign timeout    = tmo_q;
  assign busy       = state_q != StIdle;

endmodule

// File: tb/tb_sensor_trigger.sv
// tb_sensor_trigger: directed self-checking bench for sensor_trigger (scaled-down timing).
module tb_sensor_trigger;

  localparam int unsigned DistW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, enable, echo;
  logic             trig, dist_valid, timeout, busy;
  logic [DistW-1:0] distance;

  logic             rst_s_n, en_s, echo_s_in;
  logic             trig_s, valid_s, tmo_s, busy_s;
  logic [DistW-1:0] dist_s;

  sensor_trigger #(
    .TRIG_CYCLES    (10),
    .PERIOD_CYCLES  (2000),
    .TIMEOUT_CYCLES (800),
    .CYC_PER_CM     (4),
    .DIST_W         (DistW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .echo       (echo),
    .trig       (trig),
    .distance   (distance),
    .dist_valid (dist_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  sensor_trigger #(
    .TRIG_CYCLES    (10),
    .PERIOD_CYCLES  (2000),
    .TIMEOUT_CYCLES (1500),
    .CYC_PER_CM     (1),
    .DIST_W         (DistW)
  ) u_sat (
    .clk        (clk),
    .rst_n      (rst_s_n),
    .enable     (en_s),
    .echo       (echo_s_in),
    .trig       (trig_s),
    .distance   (dist_s),
    .dist_valid (valid_s),
    .timeout    (tmo_s),
    .busy       (busy_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Event monitor for the main instance, sampled on the falling edge.
  int   cyc = 0;
  int   n_rise = 0, n_fall = 0, n_valid = 0, n_tmo = 0, n_busy_low = 0, n_sat_tmo = 0;
  int   rise_cyc = 0, fall_cyc = 0, tmo_cyc = 0, busy_fall_cyc = 0, valid_dist = 0;
  logic trig_prev = 1'b0, busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    trig_prev <= trig;
    busy_prev <= busy;
    if (trig && !trig_prev) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    if (!trig && trig_prev) begin
      n_fall   <= n_fall + 1;
      fall_cyc <= cyc;
    end
    if (dist_valid) begin
      n_valid    <= n_valid + 1;
      valid_dist <= int'(distance);
    end
    if (timeout) begin
      n_tmo   <= n_tmo + 1;
      tmo_cyc <= cyc;
    end
    if (!busy && busy_prev && rst_n) busy_fall_cyc <= cyc;
    if (!busy && rst_n) n_busy_low <= n_busy_low + 1;
    if (tmo_s) n_sat_tmo <= n_sat_tmo + 1;
  end

  function automatic int evt_cnt(input int which);
    case (which)
      0:       return n_rise;
      1:       return n_fall;
      2:       return n_valid;
      default: return n_tmo;
    endcase
  endfunction

  // Wait (bounded) for one more event of the given kind: 0 rise, 1 fall, 2 valid, 3 timeout.
  task automatic wait_evt(input string tag, input int which, input int limit);
    int base;
    base = evt_cnt(which);
    for (int i = 0; i < limit && evt_cnt(which) == base; i++) @(posedge clk);
    check_eq(tag, evt_cnt(which) - base, 1);
    #1;
  endtask

  // Echo pulse of 'high' cycles starting 50 cycles after the next trig fall.
  task automatic measure(input int high, input int drop_at);
    wait_evt("trig_fall", 1, 2500);
    repeat (49) @(posedge clk);
    #1 echo = 1'b1;
    for (int i = 0; i < high; i++) begin
      if (i == drop_at) enable = 1'b0;
      @(posedge clk);
      #1;
    end
    echo = 1'b0;
  endtask

  int r0, v0, t0, b0, nr;
  int echo_len [5];
  int exp_dist [5];

  initial begin
    echo_len = '{32, 48, 64, 80, 16};
`ifdef SENSOR_AVG_EN
    exp_dist = '{8, 12, 16, 14, 13};
`else
    exp_dist = '{8, 12, 16, 20, 4};
`endif
    rst_n = 1'b0; enable = 1'b1; echo = 1'b0;
    rst_s_n = 1'b0; en_s = 1'b1; echo_s_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_trig", int'(trig), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_distance", int'(distance), 0);
    check_eq("rst_valid", int'(dist_valid), 0);
    check_eq("rst_timeout", int'(timeout), 0);

    // First period: 40-cycle echo -> 10 cm.
    rst_n = 1'b1;
    wait_evt("trig_rise1", 0, 10);
    r0 = rise_cyc; b0 = n_busy_low; v0 = n_valid; t0 = n_tmo;
    measure(40, -1);
    check_eq("trig_width", fall_cyc - r0, 10);
    wait_evt("valid1", 2, 50);
    check_eq("dist1", valid_dist, 10);
    check_eq("dist1_held", int'(distance), 10);
    wait_evt("trig_rise2", 0, 2500);
    check_eq("period1", rise_cyc - r0, 2000);
    check_eq("valid1_count", n_valid - v0, 1);
    check_eq("tmo1_count", n_tmo - t0, 0);
    check_eq("busy_held", n_busy_low - b0, 0);

    // Second period: no echo -> timeout 800 cycles after trig falls.
    r0 = rise_cyc; v0 = n_valid;
    wait_evt("tmo2", 3, 1000);
    check_eq("tmo2_time", tmo_cyc - fall_cyc, 800);
    check_eq("dist2_kept", int'(distance), 10);
    wait_evt("trig_rise3", 0, 2500);
    check_eq("period2", rise_cyc - r0, 2000);
    check_eq("valid2_count", n_valid - v0, 0);

    // Periods three and four: echo stuck high across the period boundary.
    v0 = n_valid;
    wait_evt("trig_fall3", 1, 50);
    repeat (49) @(posedge clk);
    #1 echo = 1'b1;
    wait_evt("tmo3", 3, 1000);
    check_eq("tmo3_time", tmo_cyc - fall_cyc, 800);
    wait_evt("tmo4", 3, 2500);
    check_eq("tmo4_time", tmo_cyc - fall_cyc, 800);
    echo = 1'b0;
    check_eq("stuck_no_valid", n_valid - v0, 0);
    check_eq("stuck_dist_kept", int'(distance), 10);

    // Fifth period: enable dropped mid-echo, result still delivered, then idle.
    measure(40, 20);
    r0 = rise_cyc;
    wait_evt("valid5", 2, 50);
    check_eq("dist5", int'(distance), 10);
    nr = n_rise;
    for (int i = 0; i < 2500 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_time", busy_fall_cyc - r0, 2000);
    repeat (2500) @(posedge clk);
    #1;
    check_eq("idle_no_trig", n_rise - nr, 0);
    check_eq("idle_trig_low", int'(trig), 0);

    // Reset pulsed while trig is high.
    enable = 1'b1;
    wait_evt("trig_rise6", 0, 10);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_trig", int'(trig), 0);
    check_eq("async_rst_busy", int'(busy), 0);
    check_eq("async_rst_dist", int'(distance), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Measurement series (averaged when SENSOR_AVG_EN is defined).
    for (int k = 0; k < 5; k++) begin
      measure(echo_len[k], -1);
      wait_evt("series_valid", 2, 50);
      check_eq($sformatf("series_dist%0d", k), int'(distance), exp_dist[k]);
    end

    // Saturation instance: 1100 cm worth of echo saturates an 8-bit distance.
    rst_s_n = 1'b1;
    for (int i = 0; i < 20 && !trig_s; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 20 && trig_s; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("sat_trig_fell", int'(trig_s), 0);
    repeat (50) @(posedge clk);
    #1 echo_s_in = 1'b1;
    repeat (1100) @(posedge clk);
    #1 echo_s_in = 1'b0;
    for (int i = 0; i < 20 && !valid_s; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("sat_valid", int'(valid_s), 1);
    check_eq("sat_dist", int'(dist_s), 255);
    check_eq("sat_no_tmo", n_sat_tmo, 0);
    check_eq("sat_busy", int'(busy_s), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
